// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// The optional FETCH_PERF_EN build adds performance counters to fetch_unit.
package fetch_pkg;

    typedef enum logic {
        REFILL = 1'b0,
        RUN    = 1'b1
    } fetch_state_t;

    localparam int unsigned  INSTR_BYTES      = 4;
    localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_perf_counters.sv
// Free-running fetch/stall event counters, wrapping modulo 2^32.
// Only instantiated by fetch_unit when FETCH_PERF_EN is defined.
module fetch_perf_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        fire,
    input  logic        stall,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    logic [31:0] fetch_count_reg;
    logic [31:0] stall_count_reg;

    // Redirects deliberately do not clear these; only reset does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_reg <= '0;
            stall_count_reg <= '0;
        end else begin
            if (fire)
                fetch_count_reg <= fetch_count_reg + 32'd1;
            if (stall)
                stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign fetch_count = fetch_count_reg;
    assign stall_count = stall_count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: owns the PC, hides imem's one-cycle read latency,
// replays on decode stall and squashes on redirect. Optional counters: FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 31,
    parameter logic [WIDTH:0]   RESET_PC = DEFAULT_RESET_PC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [WIDTH:0]   redirectPC,
    output logic [WIDTH:0]   rAddress,
    input  logic [WIDTH:0]   instr,
    output logic             instrValid,
    input  logic             instrReady,
    output logic [WIDTH:0]   instrOut,
    output logic [WIDTH:0]   instrPC
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]      fetchCount,
    output logic [31:0]      stallCount
`endif
);

    localparam logic [WIDTH:0] PC_STEP = (WIDTH+1)'(INSTR_BYTES);

    fetch_state_t   state_reg;
    logic [WIDTH:0] pc_reg;
    logic [WIDTH:0] pcd_reg;
    logic [WIDTH:0] redirect_target;
    logic           stall;

    assign redirect_target = {redirectPC[WIDTH:2], 2'b00};

    assign instrValid = (state_reg == RUN) && !redirect;
    assign stall      = instrValid && !instrReady;
    assign instrOut   = instrValid ? instr : '0;
    assign instrPC    = pcd_reg;

    // Replaying pcD during a stall makes imem return the same word next cycle.
    always_comb begin
        rAddress = pc_reg;
        if (redirect)
            rAddress = redirect_target;
        else if (stall)
            rAddress = pcd_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg    <= RESET_PC;
            pcd_reg   <= '0;
            state_reg <= REFILL;
        end else if (redirect) begin
            pc_reg    <= redirect_target + PC_STEP;
            pcd_reg   <= redirect_target;
            state_reg <= RUN;
        end else if (!stall) begin
            pc_reg    <= pc_reg + PC_STEP;
            pcd_reg   <= pc_reg;
            state_reg <= RUN;
        end
    end

`ifdef FETCH_PERF_EN
    fetch_perf_counters u_perf (
        .clk         (clk),
        .reset       (reset),
        .fire        (instrValid && instrReady),
        .stall       (stall),
        .fetch_count (fetchCount),
        .stall_count (stallCount)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps then random redirects/stalls against a
// delivered-stream model. Counter checks are active when FETCH_PERF_EN is defined.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectPC;
    logic [31:0] rAddress;
    logic [31:0] instr = 32'h0;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] instrOut;
    logic [31:0] instrPC;
`ifdef FETCH_PERF_EN
    logic [31:0] fetchCount;
    logic [31:0] stallCount;
`endif

    fetch_unit #(
        .WIDTH    (31),
        .RESET_PC (RST_PC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirectPC (redirectPC),
        .rAddress   (rAddress),
        .instr      (instr),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .instrOut   (instrOut),
        .instrPC    (instrPC)
`ifdef FETCH_PERF_EN
        ,
        .fetchCount (fetchCount),
        .stallCount (stallCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0093;
            32'h0000_0004: mem_word = 32'h0010_8113;
            32'h0000_0008: mem_word = 32'hFFFF_FFFF;
            default:       mem_word = {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Synchronous imem: data for the address sampled at an edge appears after it.
    always @(posedge clk) instr <= mem_word(rAddress);

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    // Model of the delivered stream: is a word due, and which address it is.
    bit          live;
    logic [31:0] show;
    logic [31:0] fc;
    logic [31:0] sc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic rdr, input logic [31:0] tgt, input logic rdy);
        logic [31:0] t;
        logic [31:0] exp_ra;
        logic        exp_v;
        redirect   = rdr;
        redirectPC = tgt;
        instrReady = rdy;
        #1;
        t      = tgt & 32'hFFFF_FFFC;
        exp_v  = live && !rdr;
        exp_ra = rdr ? t : (!live ? RST_PC : (rdy ? show + 32'd4 : show));
        check("valid", 32'(instrValid), 32'(exp_v));
        check("raddr", rAddress, exp_ra);
        if (exp_v) begin
            check("pc", instrPC, show);
            check("instr", instrOut, mem_word(show));
        end else begin
            check("instr_zero", instrOut, 32'h0);
        end
`ifdef FETCH_PERF_EN
        check("fetch_count", fetchCount, fc);
        check("stall_count", stallCount, sc);
`endif
        $display("cyc %0d rdr=%b rdy=%b valid=%b pc=%h instr=%h raddr=%h",
                 cyc, rdr, rdy, instrValid, instrPC, instrOut, rAddress);
        if (exp_v && rdy)  fc = fc + 32'd1;
        if (exp_v && !rdy) sc = sc + 32'd1;
        if (rdr) begin
            live = 1'b1;
            show = t;
        end else if (!live) begin
            live = 1'b1;
            show = RST_PC;
        end else if (rdy) begin
            show = show + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        redirect   = 1'b0;
        redirectPC = 32'h0;
        instrReady = 1'b0;
        live       = 1'b0;
        show       = 32'h0;
        fc         = 32'h0;
        sc         = 32'h0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 32'(instrValid), 32'h0);
        check("rst_raddr", rAddress, RST_PC);
        check("rst_instr", instrOut, 32'h0);
        check("rst_pc", instrPC, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Startup, then a 3-cycle stall on the word at 4, then release.
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        // Redirect while a valid word is shown.
        step(1'b1, 32'h40, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        // Redirect during a stall, unaligned target.
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h13, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        // Wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);

        repeat (300) begin
            step($urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 3) != 0);
        end

        // Asynchronous reset mid-stream.
        redirect   = 1'b0;
        instrReady = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(instrValid), 32'h0);
        check("mid_rst_raddr", rAddress, RST_PC);
        check("mid_rst_pc", instrPC, 32'h0);
        live = 1'b0;
        show = 32'h0;
        fc   = 32'h0;
        sc   = 32'h0;
`ifdef FETCH_PERF_EN
        check("mid_rst_fetch_count", fetchCount, fc);
        check("mid_rst_stall_count", stallCount, sc);
`endif
        @(negedge clk);
        reset = 1'b0;
        repeat (5) step(1'b0, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
